// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/register widths, the ALU op codes the ALU
// implements, and a helper that says whether an op code is implemented.
package alu_pkg;

  localparam int unsigned DW = 32;  // operand/result width
  localparam int unsigned RW = 5;   // register index width

  typedef enum logic [2:0] {
    ALU_SLT = 3'b000,
    ALU_SUB = 3'b001,
    ALU_ADD = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  // 010, 011 and 100 have no ALU implementation.
  function automatic logic is_legal_aluop(input logic [2:0] op);
    case (op)
      ALU_SLT, ALU_SUB, ALU_ADD, ALU_OR, ALU_AND: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source operand: register 0 reads as zero, otherwise the EX
// result wins over the WB value, which wins over the supplied value.
// Ports:
//   i_reg              source register index
//   i_val              fallback value (register-file read or held operand)
//   i_ex_en/reg/val    EX-stage forwarding source
//   i_wb_en/reg/val    WB-stage forwarding source
//   o_val              resolved operand
module operand_forward_mux #(
  parameter int unsigned DW = alu_pkg::DW,
  parameter int unsigned RW = alu_pkg::RW
) (
  input  logic [RW-1:0] i_reg,
  input  logic [DW-1:0] i_val,
  input  logic          i_ex_en,
  input  logic [RW-1:0] i_ex_reg,
  input  logic [DW-1:0] i_ex_val,
  input  logic          i_wb_en,
  input  logic [RW-1:0] i_wb_reg,
  input  logic [DW-1:0] i_wb_val,
  output logic [DW-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_reg == '0)                           o_val = '0;
    else if (i_ex_en && (i_ex_reg == i_reg))   o_val = i_ex_val;
    else if (i_wb_en && (i_wb_reg == i_reg))   o_val = i_wb_val;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register for the ALU inputs. Captures decoded operands with
// EX/WB forwarding, selects the extended immediate for b, holds one entry
// under valid/ready backpressure while re-snooping forwarding, and replaces
// unimplemented ALU ops with add while flagging them.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               squash held entry and any capture this cycle
//   in_valid/in_ready   decode-side handshake
//   id_*                decoded instruction fields and register-file reads
//   ex_fwd_*, wb_fwd_*  forwarding sources
//   out_valid/out_ready EX-side handshake
//   a, b, alucontrol    registered ALU inputs
//   illegal_op          high while the held op has no ALU implementation
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = alu_pkg::DW,
  parameter int unsigned RW = alu_pkg::RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic [15:0]   id_imm,
  input  logic          id_alusrc,
  input  logic          id_zeroext,
  input  logic [2:0]    id_alucontrol,
  input  logic          ex_fwd_en,
  input  logic [RW-1:0] ex_fwd_reg,
  input  logic [DW-1:0] ex_fwd_val,
  input  logic          wb_fwd_en,
  input  logic [RW-1:0] wb_fwd_reg,
  input  logic [DW-1:0] wb_fwd_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [2:0]    alucontrol,
  output logic          illegal_op
);

  logic          r_valid;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  alu_op_e       r_op;
  logic          r_illegal;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic          r_alusrc;

  logic          w_fire;
  logic          w_hold;
  logic [DW-1:0] w_ext;
  logic [DW-1:0] w_cap_a;
  logic [DW-1:0] w_cap_rt;
  logic [DW-1:0] w_hold_a;
  logic [DW-1:0] w_hold_b;

  assign in_ready = !r_valid || out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_hold   = r_valid && !out_ready;

  assign w_ext = id_zeroext ? {{(DW-16){1'b0}}, id_imm}
                            : {{(DW-16){id_imm[15]}}, id_imm};

  operand_forward_mux #(.DW(DW), .RW(RW)) u_cap_rs (
    .i_reg(id_rs), .i_val(id_rs_val),
    .i_ex_en(ex_fwd_en), .i_ex_reg(ex_fwd_reg), .i_ex_val(ex_fwd_val),
    .i_wb_en(wb_fwd_en), .i_wb_reg(wb_fwd_reg), .i_wb_val(wb_fwd_val),
    .o_val(w_cap_a)
  );

  operand_forward_mux #(.DW(DW), .RW(RW)) u_cap_rt (
    .i_reg(id_rt), .i_val(id_rt_val),
    .i_ex_en(ex_fwd_en), .i_ex_reg(ex_fwd_reg), .i_ex_val(ex_fwd_val),
    .i_wb_en(wb_fwd_en), .i_wb_reg(wb_fwd_reg), .i_wb_val(wb_fwd_val),
    .o_val(w_cap_rt)
  );

  // Hold snooping feeds the held operand back as the fallback value, so a
  // forwarding hit replaces it and a miss leaves it unchanged.
  operand_forward_mux #(.DW(DW), .RW(RW)) u_hold_rs (
    .i_reg(r_rs), .i_val(r_a),
    .i_ex_en(ex_fwd_en), .i_ex_reg(ex_fwd_reg), .i_ex_val(ex_fwd_val),
    .i_wb_en(wb_fwd_en), .i_wb_reg(wb_fwd_reg), .i_wb_val(wb_fwd_val),
    .o_val(w_hold_a)
  );

  logic [DW-1:0] w_hold_rt;
  operand_forward_mux #(.DW(DW), .RW(RW)) u_hold_rt (
    .i_reg(r_rt), .i_val(r_b),
    .i_ex_en(ex_fwd_en), .i_ex_reg(ex_fwd_reg), .i_ex_val(ex_fwd_val),
    .i_wb_en(wb_fwd_en), .i_wb_reg(wb_fwd_reg), .i_wb_val(wb_fwd_val),
    .o_val(w_hold_rt)
  );

  // An immediate operand never changes while held.
  assign w_hold_b = r_alusrc ? r_b : w_hold_rt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= ALU_ADD;
      r_illegal <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_alusrc  <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_fire) begin
      r_valid   <= 1'b1;
      r_a       <= w_cap_a;
      r_b       <= id_alusrc ? w_ext : w_cap_rt;
      r_op      <= is_legal_aluop(id_alucontrol) ? alu_op_e'(id_alucontrol) : ALU_ADD;
      r_illegal <= !is_legal_aluop(id_alucontrol);
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_alusrc  <= id_alusrc;
    end else if (w_hold) begin
      r_a <= w_hold_a;
      r_b <= w_hold_b;
    end else begin
      // Consumed with nothing new: operands keep their last values.
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign a          = r_a;
  assign b          = r_b;
  assign alucontrol = r_op;
  assign illegal_op = r_illegal;

endmodule
